// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline-side source/destination info in,
// stall/flush/forward controls, perf counters and error flag out.
interface hazard_ctrl_if #(
  parameter int unsigned CNTW = 16
);
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            ResultSrcE;
  logic            PCSrcE;
  logic            retE;
  logic [4:0]      RdM;
  logic            RegWriteM;
  logic            MemReqM;
  logic            MemReadyM;
  logic [4:0]      RdW;
  logic            RegWriteW;

  logic            StallF;
  logic            StallD;
  logic            StallE;
  logic            StallM;
  logic            FlushD;
  logic            FlushE;
  logic            FlushW;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
  logic            mem_err;

  // Pipeline side: supplies stage info, consumes controls
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, retE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, stall_cnt, flush_cnt, mem_err
  );

  // Controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, retE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, stall_cnt, flush_cnt, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Priority: memory wait > control redirect > load-use. Keeps saturating
// stall/flush event counters and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [CNTW-1:0] LP_TIMEOUT = CNTW'(TIMEOUT);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_wait_cnt;
  logic [CNTW-1:0] w_wait_cnt_nxt;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;
  logic            r_mem_err;
  logic            w_mem_err_set;

  logic            w_lw_stall;
  logic            w_redirect;
  logic            w_mwait;
  logic            w_stall_f;
  logic            w_stall_d;
  logic            w_stall_e;
  logic            w_stall_m;
  logic            w_flush_d;
  logic            w_flush_e;
  logic            w_flush_w;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;

  // Operand forwarding into Execute; Memory-stage result wins over Writeback
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == bus.Rs1E))
      w_fwd_a = 2'b10;
    else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs1E))
      w_fwd_a = 2'b01;
    if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == bus.Rs2E))
      w_fwd_b = 2'b10;
    else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs2E))
      w_fwd_b = 2'b01;
  end

  assign w_lw_stall = bus.ResultSrcE && (bus.RdE != '0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  assign w_redirect = bus.PCSrcE || bus.retE;
  assign w_mwait    = ((r_state == S_RUN)  && bus.MemReqM && !bus.MemReadyM) ||
                      ((r_state == S_WAIT) && !bus.MemReadyM && (r_wait_cnt < LP_TIMEOUT));

  // FSM next-state: track an outstanding data-memory access and its wait time
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_set  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.MemReqM && !bus.MemReadyM) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = CNTW'(1);
        end
      end
      S_WAIT: begin
        if (bus.MemReadyM) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt >= LP_TIMEOUT) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
          w_mem_err_set  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNTW'(1);
        end
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Stall/flush resolution in priority order
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (w_mwait) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_redirect) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  // State register, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_mem_err_set)
        r_mem_err <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      if (w_flush_e && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
    end
  end

  assign bus.StallF    = w_stall_f;
  assign bus.StallD    = w_stall_d;
  assign bus.StallE    = w_stall_e;
  assign bus.StallM    = w_stall_m;
  assign bus.FlushD    = w_flush_d;
  assign bus.FlushE    = w_flush_e;
  assign bus.FlushW    = w_flush_w;
  assign bus.ForwardAE = w_fwd_a;
  assign bus.ForwardBE = w_fwd_b;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
  assign bus.mem_err   = r_mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=4, CNTW=4).
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  hazard_ctrl_if #(.CNTW(4)) bus ();

  hazard_ctrl #(.TIMEOUT(4), .CNTW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.ResultSrcE = 1'b0; bus.PCSrcE = 1'b0; bus.retE = 1'b0;
    bus.RdM = '0; bus.RegWriteM = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
    bus.RdW = '0; bus.RegWriteW = 1'b0;
  endtask

  task automatic check_ctl(input string tag, input logic [6:0] exp);
    check(tag, {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                bus.FlushD, bus.FlushE, bus.FlushW}, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst = 1'b1;
    #12;
    // Reset state: {SF,SD,SE,SM,FD,FE,FW}
    check_ctl("rst_ctl", 7'b0000000);
    check("rst_fwd", {bus.ForwardAE, bus.ForwardBE}, 4'b0000);
    check("rst_scnt", bus.stall_cnt, 0);
    check("rst_fcnt", bus.flush_cnt, 0);
    check("rst_err", bus.mem_err, 0);
    rst = 1'b0;
    tick();

    // RAW forwarding
    bus.RdM = 5; bus.RegWriteM = 1'b1; bus.RdW = 5; bus.RegWriteW = 1'b1;
    bus.Rs1E = 5; bus.Rs2E = 0;
    #1;
    check("fwdA_M", bus.ForwardAE, 2'b10);
    check("fwdB_x0", bus.ForwardBE, 2'b00);
    bus.RegWriteM = 1'b0;
    #1;
    check("fwdA_W", bus.ForwardAE, 2'b01);
    bus.RdM = 0; bus.RdW = 0;
    #1;
    check("fwdA_zero", bus.ForwardAE, 2'b00);
    bus.RdM = 9; bus.RegWriteM = 1'b1; bus.RdW = 3; bus.Rs1E = 3; bus.Rs2E = 9;
    #1;
    check("fwdA_W2", bus.ForwardAE, 2'b01);
    check("fwdB_M", bus.ForwardBE, 2'b10);
    clear_inputs();
    tick();

    // Load-use
    bus.ResultSrcE = 1'b1; bus.RdE = 7; bus.Rs2D = 7;
    #1;
    check_ctl("lw_ctl", 7'b1100010);
    tick();
    clear_inputs();
    #1;
    check("lw_scnt", bus.stall_cnt, 1);
    check("lw_fcnt", bus.flush_cnt, 1);
    bus.ResultSrcE = 1'b1; bus.RdE = 0; bus.Rs1D = 0; bus.Rs2D = 0;
    #1;
    check_ctl("lw_x0_ctl", 7'b0000000);
    tick();
    clear_inputs();
    check("lw_x0_scnt", bus.stall_cnt, 1);

    // Redirect beats load-use
    bus.ResultSrcE = 1'b1; bus.RdE = 7; bus.Rs1D = 7; bus.PCSrcE = 1'b1;
    #1;
    check_ctl("redir_ctl", 7'b0000110);
    tick();
    clear_inputs();
    bus.retE = 1'b1;
    #1;
    check_ctl("ret_ctl", 7'b0000110);
    tick();
    clear_inputs();
    check("redir_scnt", bus.stall_cnt, 1);
    check("redir_fcnt", bus.flush_cnt, 3);

    // Memory wait: 3 stalled cycles, redirect held off until ready
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctl($sformatf("mwait_ctl%0d", i), 7'b1111001);
      tick();
    end
    bus.MemReadyM = 1'b1;
    #1;
    check_ctl("mready_ctl", 7'b0000110);
    tick();
    clear_inputs();
    #1;
    check_ctl("mdone_ctl", 7'b0000000);
    check("mwait_scnt", bus.stall_cnt, 4);
    check("mwait_fcnt", bus.flush_cnt, 4);
    check("mwait_err", bus.mem_err, 0);

    // Timeout: 4 stalled cycles, released at wait_cnt==TIMEOUT
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_ctl($sformatf("to_ctl%0d", i), 7'b1111001);
      tick();
    end
    #1;
    check_ctl("to_release", 7'b0000000);
    check("to_err_pre", bus.mem_err, 0);
    bus.MemReqM = 1'b0;
    tick();
    check("to_err", bus.mem_err, 1);
    check("to_scnt", bus.stall_cnt, 8);
    tick();
    tick();
    check("to_err_sticky", bus.mem_err, 1);
    check_ctl("to_idle", 7'b0000000);

    // Async reset mid-WAIT
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    tick();
    tick();
    bus.MemReqM = 1'b0;
    #1;
    check("wait_held", bus.StallF, 1);
    rst = 1'b1;
    #1;
    check_ctl("arst_ctl", 7'b0000000);
    check("arst_scnt", bus.stall_cnt, 0);
    check("arst_fcnt", bus.flush_cnt, 0);
    check("arst_err", bus.mem_err, 0);
    #2;
    rst = 1'b0;
    tick();

    // Saturation at 2^CNTW-1 = 15
    bus.ResultSrcE = 1'b1; bus.RdE = 4; bus.Rs1D = 4;
    for (int i = 0; i < 14; i++) tick();
    check("sat_scnt14", bus.stall_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_scnt", bus.stall_cnt, 15);
    check("sat_fcnt", bus.flush_cnt, 15);
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Drives stall, flush and forward controls for the F/D, D/E, E/M and M/W pipeline registers; the Flush input of the D/E register is driven from FlushE.
- Resolves three hazard classes: load-use, control redirect (taken beq or ret) and multi-cycle data-memory wait.
- Keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
- TIMEOUT, 255, maximum consecutive memory-wait cycles before abort; 1..2^CNTW-1.
- CNTW, 16, width of perf counters and wait counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  5 each  source regs in Decode
- Rs1E, Rs2E  in  5 each  source regs in Execute
- RdE  in  5  destination in Execute
- ResultSrcE  in  1  1 = load in Execute
- PCSrcE  in  1  taken beq in Execute
- retE  in  1  ret in Execute
- RdM  in  5  destination in Memory
- RegWriteM  in  1  write enable in Memory
- MemReqM  in  1  data-memory access in Memory
- MemReadyM  in  1  data-memory completion
- RdW  in  5  destination in Writeback
- RegWriteW  in  1  write enable in Writeback
- StallF, StallD, StallE, StallM  out  1 each  hold the PC and the F/D, D/E and E/M registers
- FlushD, FlushE, FlushW  out  1 each  bubble the F/D, D/E and M/W registers
- ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = W result, 10 = M ALU result
- stall_cnt, flush_cnt  out  CNTW each  saturating event counters
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst=1): state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_err=0. With all inputs at 0, every combinational output is 0.
- Forwarding (combinational, zero latency), ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is the same using Rs2E.
- Hazard terms:
  - lw_stall = ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - redirect = PCSrcE || retE.
  - mwait = (state==RUN && MemReqM && !MemReadyM) || (state==WAIT && !MemReadyM && wait_cnt<TIMEOUT).
- Priority, highest first, all same-cycle combinational:
  1. mwait: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. A redirect or lw_stall present this cycle is not acted on; E is frozen, so its inputs are re-evaluated after release.
  2. redirect: FlushD=FlushE=1, no stalls. Overrides lw_stall, because the loaded-from instruction in D is discarded.
  3. lw_stall: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall and flush outputs are 0.
- FSM states RUN and WAIT, with wait_cnt:
  - RUN -> WAIT when MemReqM && !MemReadyM; wait_cnt <= 1.
  - In WAIT, MemReadyM=1 -> RUN, wait_cnt <= 0. mwait is 0 in that cycle, so the pipeline advances in the same cycle ready is seen.
  - In WAIT, wait_cnt==TIMEOUT with !MemReadyM -> RUN, mem_err <= 1, wait_cnt <= 0. The pipeline is released that cycle and the access is treated as complete.
  - Otherwise, in WAIT, wait_cnt increments.
  - A MemReqM with MemReadyM=1 in RUN is a zero-wait access and never enters WAIT.
- Counters:
  - stall_cnt increments on every cycle with StallF=1 (load-use or mwait).
  - flush_cnt increments on every cycle with FlushE=1 (redirect or load-use).
  - Both saturate at 2^CNTW-1 and never wrap.
- mem_err is cleared only by rst.
- rst asserted mid-WAIT returns to RUN immediately and drops all stalls.

Test Plan:
1. RAW forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Drop RegWriteM -> ForwardAE=01. Set RdM=RdW=0 -> ForwardAE=00.
2. Load-use: ResultSrcE=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 that cycle; stall_cnt=1 and flush_cnt=1 afterwards. Repeat with RdE=0 -> no stall.
3. Redirect over load-use: PCSrcE=1 plus the same lw_stall condition -> FlushD=FlushE=1, StallF=0. retE=1 alone gives the identical response.
4. Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM=1 and FlushW=1 for exactly 3 cycles, 0 on the ready cycle. A concurrent PCSrcE=1 produces FlushE only on the ready cycle.
5. Timeout: TIMEOUT=4, MemReadyM held 0 -> stalls for 4 cycles (RUN entry plus wait_cnt 1..3), released on the cycle wait_cnt==4. mem_err=1 from the next edge and stays set until rst.
6. Reset mid-WAIT and saturation:
   - Assert rst asynchronously during WAIT -> stalls drop without a clock edge; counters and mem_err read 0.
   - With CNTW=4, apply 20 load-use cycles -> stall_cnt=15.
